coinc_result_streamer: RTL

Downstream readout stage of the coincidence detector. When the detector closes a measurement window, this block snapshots the clock count, per-channel counts and pair counts in a single cycle. It then streams the snapshot as one framed AXI-Stream packet toward the DMA/PS side, so the detector can start the next window immediately.

---
 rtl/coinc_result_streamer_if.sv | 32 +++
 rtl/coinc_result_streamer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/coinc_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : coinc_result_streamer_if
// Brief    : AXI-Stream master/slave bundle carrying the coincidence result
//            frames (data, valid, ready, last).
// Revision : 1.0 - initial release
// ============================================================================
interface coinc_result_streamer_if #(
    parameter int NBITS = 32
);
    logic [NBITS-1:0] M_tdata;
    logic             M_tvalid;
    logic             M_tready;
    logic             M_tlast;

    // Producer side: drives the beat, observes ready.
    modport master (
        output M_tdata,
        output M_tvalid,
        output M_tlast,
        input  M_tready
    );

    // Consumer side: observes the beat, drives ready.
    modport slave (
        input  M_tdata,
        input  M_tvalid,
        input  M_tlast,
        output M_tready
    );
endinterface
`default_nettype wire

// File: rtl/coinc_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : coinc_result_streamer
// Brief    : Captures the coincidence-window counters on a Done_i pulse and
//            streams them as one framed AXI-Stream packet:
//              header, Cnt_Clk, Cnt_chann[0..NCHAN-1], Cnt_pairs[0..NCOMB-1]
//            Done_i pulses arriving while a frame is in flight are counted
//            as drops (saturating) and never disturb the snapshot.
// Options  : `define COINC_RESULT_STREAMER_CHKSUM_EN appends a trailer word
//            equal to the XOR of every preceding word (header included);
//            M_tlast then moves onto the trailer.
// Revision : 1.0 - initial release
// ============================================================================
module coinc_result_streamer #(
    parameter  int NCHAN = 4,
    parameter  int NBITS = 32,
    localparam int NCOMB = NCHAN * (NCHAN - 1) / 2
) (
    input  wire                      Clk,
    input  wire                      Rst_n,
    input  wire                      Restart_i,
    input  wire                      Done_i,
    input  wire  [NBITS-1:0]         Cnt_Clk_i,
    input  wire  [NCHAN*NBITS-1:0]   Cnt_chann_i,
    input  wire  [NCOMB*NBITS-1:0]   Cnt_pairs_i,
    coinc_result_streamer_if.master  m_axis,
    output logic                     Busy_o,
    output logic [15:0]              Dropped_o
);

    // ------------------------------------------------------------------------
    // Frame geometry
    // ------------------------------------------------------------------------
`ifdef COINC_RESULT_STREAMER_CHKSUM_EN
    localparam int NTRL = 1;
`else
    localparam int NTRL = 0;
`endif
    // Words following the header: clock count, channels, pairs, [trailer].
    localparam int NBODY = 1 + NCHAN + NCOMB + NTRL;
    localparam int IDX_W = $clog2(NBODY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBODY - 1);

    localparam logic [7:0]  HDR_MAGIC = 8'hA5;
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_BODY = 2'd2;

    logic [1:0]             state_q,      state_d;
    logic [IDX_W-1:0]       idx_q,        idx_d;
    logic [15:0]            frame_cnt_q,  frame_cnt_d;
    logic [15:0]            dropped_q,    dropped_d;
    logic [NBITS-1:0]       hdr_q,        hdr_d;
    logic [NBITS-1:0]       clk_snap_q,   clk_snap_d;
    logic [NCHAN*NBITS-1:0] chann_snap_q, chann_snap_d;
    logic [NCOMB*NBITS-1:0] pairs_snap_q, pairs_snap_d;

    logic [NBITS-1:0]       w_body [NBODY];
    logic [NBITS-1:0]       w_tdata;
    logic                   w_tvalid;
    logic                   w_tlast;
    logic                   w_hs;
    logic                   w_capture;
    logic                   w_drop;

`ifdef COINC_RESULT_STREAMER_CHKSUM_EN
    logic [NBITS-1:0]       chk_q, chk_d;
`endif

    // ------------------------------------------------------------------------
    // Output beat
    // ------------------------------------------------------------------------
    // The beat is a pure function of registered state, so data/last remain
    // stable for as long as the consumer stalls.
    assign w_tvalid  = (state_q != S_IDLE);
    assign w_tlast   = (state_q == S_BODY) && (idx_q == LAST_IDX);
    assign w_hs      = w_tvalid & m_axis.M_tready;
    assign w_capture = (state_q == S_IDLE) & Done_i;
    // A pulse in any non-idle state is lost, including the final-word cycle.
    assign w_drop    = (state_q != S_IDLE) & Done_i;

    // Lay out the body words in transmission order.
    always_comb begin
        for (int k = 0; k < NBODY; k++) begin
            w_body[k] = '0;
        end
        w_body[0] = clk_snap_q;
        for (int k = 0; k < NCHAN; k++) begin
            w_body[1 + k] = chann_snap_q[k*NBITS +: NBITS];
        end
        for (int p = 0; p < NCOMB; p++) begin
            w_body[1 + NCHAN + p] = pairs_snap_q[p*NBITS +: NBITS];
        end
`ifdef COINC_RESULT_STREAMER_CHKSUM_EN
        w_body[NBODY - 1] = chk_q;
`endif
    end

    // Select the word currently presented on the stream.
    always_comb begin
        w_tdata = '0;
        case (state_q)
            S_HDR:   w_tdata = hdr_q;
            S_BODY:  w_tdata = w_body[idx_q];
            default: w_tdata = '0;
        endcase
    end

    assign m_axis.M_tdata  = w_tdata;
    assign m_axis.M_tvalid = w_tvalid;
    assign m_axis.M_tlast  = w_tlast;
    assign Busy_o          = w_tvalid;
    assign Dropped_o       = dropped_q;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // Sequencer, snapshot capture, frame counter and drop counter.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_cnt_d  = frame_cnt_q;
        dropped_d    = dropped_q;
        hdr_d        = hdr_q;
        clk_snap_d   = clk_snap_q;
        chann_snap_d = chann_snap_q;
        pairs_snap_d = pairs_snap_q;

        case (state_q)
            S_IDLE: begin
                if (Done_i) begin
                    clk_snap_d   = Cnt_Clk_i;
                    chann_snap_d = Cnt_chann_i;
                    pairs_snap_d = Cnt_pairs_i;
                    // Header is frozen here so a later Restart_i cannot
                    // alter a word that is already on the bus.
                    hdr_d                = '0;
                    hdr_d[NBITS-1 -: 8]  = HDR_MAGIC;
                    hdr_d[15:0]          = Restart_i ? 16'h0000 : frame_cnt_q;
                    state_d              = S_HDR;
                end
            end
            S_HDR: begin
                if (w_hs) begin
                    state_d = S_BODY;
                    idx_d   = '0;
                end
            end
            S_BODY: begin
                if (w_hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = S_IDLE;
                        idx_d       = '0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        if (w_drop && (dropped_q != CNT_MAX)) begin
            dropped_d = dropped_q + 16'd1;
        end

        // Restart clears both counters and overrides a coincident drop or
        // frame completion; the frame in flight carries on untouched.
        if (Restart_i) begin
            frame_cnt_d = '0;
            dropped_d   = '0;
        end
    end

    // State and snapshot registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            frame_cnt_q  <= '0;
            dropped_q    <= '0;
            hdr_q        <= '0;
            clk_snap_q   <= '0;
            chann_snap_q <= '0;
            pairs_snap_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_cnt_q  <= frame_cnt_d;
            dropped_q    <= dropped_d;
            hdr_q        <= hdr_d;
            clk_snap_q   <= clk_snap_d;
            chann_snap_q <= chann_snap_d;
            pairs_snap_q <= pairs_snap_d;
        end
    end

`ifdef COINC_RESULT_STREAMER_CHKSUM_EN
    // Running XOR of accepted words; it only moves on a handshake, so the
    // trailer value is already final when the trailer is presented.
    always_comb begin
        chk_d = chk_q;
        if (w_capture) begin
            chk_d = '0;
        end else if (w_hs) begin
            chk_d = chk_q ^ w_tdata;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            chk_q <= '0;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

endmodule
`default_nettype wire
